// File: rtl/leaf_link_hub_if.sv
// leaf_link_hub_if: valid/ready link bundle between the root, the hub and NUM_LEAVES leaves.
//   down_rx_*  : root -> hub message (one DATA_WIDTH word)
//   down_tx_*  : hub -> leaves, slice i of data / bit i of valid,ready belongs to leaf i
//   up_rx_*    : leaves -> hub, sliced the same way
//   up_tx_*    : hub -> root merged upward stream
//   drop_count : root messages discarded for an unknown destination
// Modports: master = root/leaf side (environment), slave = hub.
interface leaf_link_hub_if #(
  parameter int unsigned NUM_LEAVES = 4,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]            down_rx_data;
  logic                             down_rx_valid;
  logic                             down_rx_ready;
  logic [DATA_WIDTH*NUM_LEAVES-1:0] down_tx_data;
  logic [NUM_LEAVES-1:0]            down_tx_valid;
  logic [NUM_LEAVES-1:0]            down_tx_ready;
  logic [DATA_WIDTH*NUM_LEAVES-1:0] up_rx_data;
  logic [NUM_LEAVES-1:0]            up_rx_valid;
  logic [NUM_LEAVES-1:0]            up_rx_ready;
  logic [DATA_WIDTH-1:0]            up_tx_data;
  logic                             up_tx_valid;
  logic                             up_tx_ready;
  logic [15:0]                      drop_count;

  modport master (
    output down_rx_data, down_rx_valid, down_tx_ready,
    output up_rx_data, up_rx_valid, up_tx_ready,
    input  down_rx_ready, down_tx_data, down_tx_valid,
    input  up_rx_ready, up_tx_data, up_tx_valid, drop_count
  );

  modport slave (
    input  down_rx_data, down_rx_valid, down_tx_ready,
    input  up_rx_data, up_rx_valid, up_tx_ready,
    output down_rx_ready, down_tx_data, down_tx_valid,
    output up_rx_ready, up_tx_data, up_tx_valid, drop_count
  );
endinterface

// File: rtl/leaf_link_hub.sv
// leaf_link_hub: root-side hub linking one root port to NUM_LEAVES leaf ports.
//   Down path: root message held in one register and delivered to the leaf named by its
//   destination ID field (leaf i = ID i+1) or to every leaf for BROADCAST_ID; unknown IDs
//   are consumed and counted in drop_count (saturating).
//   Up path: per-leaf FIFO_DEPTH FIFOs merged by a round-robin arbiter into a registered
//   root up-link.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : leaf_link_hub_if.slave carrying all root/leaf valid/ready links and drop_count
// Build option: define LINK_HUB_SRC_TAG_EN to overwrite the ID field of every upward
//   message with the source leaf ID (i+1); undefined, upward messages pass unmodified.
module leaf_link_hub #(
  parameter int unsigned NUM_LEAVES   = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEST_LSB     = 56,
  parameter logic [7:0]  BROADCAST_ID = 8'hFF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic            clk,
  input logic            reset,
  leaf_link_hub_if.slave bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} hold_state_e;

  // ---------------------------------------------------------------- down path
  hold_state_e           r_state, w_state_nxt;
  logic [NUM_LEAVES-1:0] r_pend, w_pend_nxt, w_new_mask;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [15:0]           r_drop_count;
  logic [7:0]            w_dest;
  logic                  w_dest_ok, w_rx_ready, w_rx_acc;

  assign w_dest = bus.down_rx_data[DEST_LSB +: 8];

  // Ready when empty, or when every still-pending leaf takes the message this cycle.
  assign w_rx_ready = (r_state == S_IDLE) || ((r_pend & ~bus.down_tx_ready) == '0);
  assign w_rx_acc   = bus.down_rx_valid & w_rx_ready;

  // Destination decode into a pending mask.
  always_comb begin
    w_new_mask = '0;
    w_dest_ok  = 1'b0;
    if (w_dest == BROADCAST_ID) begin
      w_new_mask = '1;
      w_dest_ok  = 1'b1;
    end else if ((w_dest != 8'd0) && (32'(w_dest) <= NUM_LEAVES)) begin
      w_new_mask = NUM_LEAVES'(1) << (w_dest - 8'd1);
      w_dest_ok  = 1'b1;
    end
  end

  // Hold FSM next state: pending bits clear per leaf handshake, accepted message refills.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend & ~bus.down_tx_ready;
    if (w_rx_acc) begin
      w_pend_nxt = w_pend_nxt | w_new_mask;
    end
    case (r_state)
      S_IDLE:  if (w_pend_nxt != '0) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_pend_nxt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pend       <= '0;
      r_hold_data  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_rx_acc && w_dest_ok) begin
        r_hold_data <= bus.down_rx_data;
      end
      if (w_rx_acc && !w_dest_ok && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign bus.down_rx_ready = w_rx_ready;
  assign bus.down_tx_valid = r_pend;
  assign bus.down_tx_data  = {NUM_LEAVES{r_hold_data}};
  assign bus.drop_count    = r_drop_count;

  // ---------------------------------------------------------------- up path
  logic [NUM_LEAVES-1:0] w_full, w_nonempty;
  logic [DATA_WIDTH-1:0] w_fifo_dout [NUM_LEAVES];
  logic [PW-1:0]         r_ptr, w_grant;
  logic                  w_any, w_load;
  logic [DATA_WIDTH-1:0] w_load_data, r_up_data;
  logic                  r_up_valid;

  for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_full, w_wr, w_rd;

    assign w_wr = bus.up_rx_valid[g] & ~r_full;
    assign w_rd = w_load & (w_grant == PW'(g));

    // Occupancy update; simultaneous read and write leaves the count unchanged.
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr && !w_rd) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else if (!w_wr && w_rd) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
        r_full <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_full <= (w_cnt_nxt == CW'(FIFO_DEPTH));
        if (w_wr) r_wptr <= r_wptr + AW'(1);
        if (w_rd) r_rptr <= r_rptr + AW'(1);
      end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
      if (w_wr) begin
        r_mem[r_wptr] <= bus.up_rx_data[g*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign w_full[g]      = r_full;
    assign w_nonempty[g]  = (r_cnt != '0);
    assign w_fifo_dout[g] = r_mem[r_rptr];
  end

  assign bus.up_rx_ready = ~w_full;

  // Round-robin grant: first non-empty FIFO at or after r_ptr. Scanning from the far end
  // lets the nearest candidate be the last assignment.
  always_comb begin
    int unsigned w_idx;
    w_grant = r_ptr;
    w_idx   = 0;
    for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
      w_idx = (32'(r_ptr) + 32'(k)) % NUM_LEAVES;
      if (w_nonempty[w_idx]) begin
        w_grant = PW'(w_idx);
      end
    end
  end

  assign w_any  = |w_nonempty;
  assign w_load = (~r_up_valid | bus.up_tx_ready) & w_any;

`ifdef LINK_HUB_SRC_TAG_EN
  // Stamp the source leaf ID into the ID field on its way to the root.
  always_comb begin
    w_load_data                   = w_fifo_dout[w_grant];
    w_load_data[DEST_LSB +: 8]    = 8'(w_grant) + 8'd1;
  end
`else
  assign w_load_data = w_fifo_dout[w_grant];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up_valid <= 1'b0;
      r_up_data  <= '0;
      r_ptr      <= '0;
    end else if (w_load) begin
      r_up_valid <= 1'b1;
      r_up_data  <= w_load_data;
      r_ptr      <= (w_grant == PW'(NUM_LEAVES - 1)) ? '0 : w_grant + PW'(1);
    end else if (bus.up_tx_ready) begin
      r_up_valid <= 1'b0;
    end
  end

  assign bus.up_tx_valid = r_up_valid;
  assign bus.up_tx_data  = r_up_data;
endmodule

// File: tb/tb_leaf_link_hub.sv
// tb_leaf_link_hub: self-checking bench for leaf_link_hub (NUM_LEAVES=4, 64-bit links).
// Directed vector table for the down path, hand-written multi-cycle sequences, and a
// randomized run checked against a queue-based reference model.
module tb_leaf_link_hub;
  localparam int unsigned NL    = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
`ifdef LINK_HUB_SRC_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_err = 0;
  int   n_chk = 0;

  leaf_link_hub_if #(.NUM_LEAVES(NL), .DATA_WIDTH(DW)) bus ();

  leaf_link_hub #(
    .NUM_LEAVES(NL), .DATA_WIDTH(DW), .DEST_LSB(56),
    .BROADCAST_ID(8'hFF), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dest;
    logic [55:0] body;
    logic [3:0]  exp_mask;
  } dvec_t;
  dvec_t vecs [8];

  // reference model state
  logic [3:0]  m_pend;
  logic [63:0] m_hold;
  logic [15:0] m_drop;
  int          m_ptr;
  logic        m_ov;
  logic [63:0] m_od;
  logic [63:0] mq [NL][$];
  logic [3:0]  pred_urdy, nxt_pend;
  logic        pred_drdy, found;
  logic [7:0]  d;
  int          j;
  int          rc [4];
  logic [3:0]  rdy, pend;
  logic [15:0] exp_drop;
  logic [7:0]  dests [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int leaf, input int k);
    return {8'h00, 8'(leaf), 8'(k), 40'h00_CAFE_F00D};
  endfunction

  function automatic logic [63:0] tag(input logic [63:0] dat, input int leaf);
    logic [63:0] r;
    r = dat;
    if (TAG_EN) r[63:56] = 8'(leaf + 1);
    return r;
  endfunction

  task automatic quiet();
    bus.down_rx_valid = 1'b0;
    bus.down_rx_data  = '0;
    bus.down_tx_ready = '0;
    bus.up_rx_valid   = '0;
    bus.up_rx_data    = '0;
    bus.up_tx_ready   = 1'b0;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_dvalid"}, bus.down_tx_valid, 0);
    chk({pfx, "_ddata"}, bus.down_tx_data, 0);
    chk({pfx, "_uvalid"}, bus.up_tx_valid, 0);
    chk({pfx, "_udata"}, bus.up_tx_data, 0);
    chk({pfx, "_drop"}, bus.drop_count, 0);
    chk({pfx, "_urdy"}, bus.up_rx_ready, 4'hF);
    chk({pfx, "_drdy"}, bus.down_rx_ready, 1);
  endtask

  initial begin
    vecs[0] = '{8'd3,  56'h0000_0000_0000_A5, 4'b0100};
    vecs[1] = '{8'd0,  56'h0000_0000_0000_11, 4'b0000};
    vecs[2] = '{8'd7,  56'h0000_0000_0000_22, 4'b0000};
    vecs[3] = '{8'd1,  56'h1234_5678_9ABC_DE, 4'b0001};
    vecs[4] = '{8'hFF, 56'hBEEF_0000_FACE_01, 4'b1111};
    vecs[5] = '{8'd4,  56'h0F0F_0F0F_0F0F_0F, 4'b1000};
    vecs[6] = '{8'd5,  56'h0000_0000_0000_33, 4'b0000};
    vecs[7] = '{8'd2,  56'hAAAA_5555_AAAA_55, 4'b0010};
    dests = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'hFF, 8'hFF};
    rc = '{0, 2, 5, 1};
    exp_drop = '0;

    // ---- reset state
    reset = 1'b0;
    quiet();
    repeat (2) @(negedge clk);
    check_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    // ---- down-path vector table: one message, check routing, then let leaves drain
    for (int v = 0; v < 8; v++) begin
      bus.down_tx_ready = '0;
      bus.down_rx_data  = {vecs[v].dest, vecs[v].body};
      bus.down_rx_valid = 1'b1;
      #1 chk($sformatf("tbl%0d_rx_ready", v), bus.down_rx_ready, 1);
      @(negedge clk);
      bus.down_rx_valid = 1'b0;
      if (vecs[v].exp_mask == '0) exp_drop++;
      #1;
      chk($sformatf("tbl%0d_valid", v), bus.down_tx_valid, vecs[v].exp_mask);
      chk($sformatf("tbl%0d_drop", v), bus.drop_count, exp_drop);
      if (vecs[v].exp_mask != '0)
        chk($sformatf("tbl%0d_data", v), bus.down_tx_data, {NL{vecs[v].dest, vecs[v].body}});
      bus.down_tx_ready = '1;
      @(negedge clk);
      #1 chk($sformatf("tbl%0d_clear", v), bus.down_tx_valid, 0);
    end

    // ---- broadcast with skewed leaf readiness, next message waits for the slowest leaf
    bus.down_tx_ready = '0;
    bus.down_rx_data  = {8'hFF, 56'h0B0B_0B0B};
    bus.down_rx_valid = 1'b1;
    @(negedge clk);
    bus.down_rx_data  = {8'h02, 56'h2222_2222};
    for (int c = 0; c <= 5; c++) begin
      for (int i = 0; i < 4; i++) begin
        rdy[i]  = (rc[i] == c);
        pend[i] = (rc[i] >= c);
      end
      bus.down_tx_ready = rdy;
      #1;
      chk($sformatf("bc_valid_c%0d", c), bus.down_tx_valid, pend);
      chk($sformatf("bc_rx_ready_c%0d", c), bus.down_rx_ready, (c == 5));
      @(negedge clk);
    end
    bus.down_rx_valid = 1'b0;
    bus.down_tx_ready = '0;
    #1;
    chk("bc_next_valid", bus.down_tx_valid, 4'b0010);
    chk("bc_next_data", bus.down_tx_data[127:64], {8'h02, 56'h2222_2222});
    bus.down_tx_ready = '1;
    @(negedge clk);
    #1 chk("bc_next_clear", bus.down_tx_valid, 0);
    bus.down_tx_ready = '0;

    // ---- round-robin fairness: 4 leaves x 3 messages, root always ready
    bus.up_tx_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c < 3) begin
        bus.up_rx_valid = 4'hF;
        for (int i = 0; i < 4; i++) bus.up_rx_data[i*64 +: 64] = mk(i, c);
      end else begin
        bus.up_rx_valid = '0;
      end
      #1;
      if (c < 2 || c == 14) begin
        chk($sformatf("rr_idle_c%0d", c), bus.up_tx_valid, 0);
      end else begin
        chk($sformatf("rr_valid_c%0d", c), bus.up_tx_valid, 1);
        chk($sformatf("rr_data_c%0d", c), bus.up_tx_data,
            tag(mk((c - 2) % 4, (c - 2) / 4), (c - 2) % 4));
      end
      @(negedge clk);
    end

    // ---- backpressure: leaf 1 fills FIFO plus output register, then drains in order
    bus.up_tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.up_rx_valid = 4'b0010;
      bus.up_rx_data[64 +: 64] = mk(1, 10 + c);
      #1 chk($sformatf("bp_rdy_c%0d", c), bus.up_rx_ready[1], 1);
      @(negedge clk);
    end
    bus.up_rx_valid = '0;
    #1;
    chk("bp_full", bus.up_rx_ready[1], 0);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("bp_stall_valid%0d", s), bus.up_tx_valid, 1);
      chk($sformatf("bp_stall_data%0d", s), bus.up_tx_data, tag(mk(1, 10), 1));
      @(negedge clk);
      #1;
    end
    bus.up_tx_ready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      #1;
      chk($sformatf("bp_out_valid%0d", m), bus.up_tx_valid, 1);
      chk($sformatf("bp_out_data%0d", m), bus.up_tx_data, tag(mk(1, 10 + m), 1));
      @(negedge clk);
    end
    #1;
    chk("bp_done_valid", bus.up_tx_valid, 0);
    chk("bp_done_rdy", bus.up_rx_ready, 4'hF);

    // ---- reset pulse so the model starts from a known state
    reset = 1'b0;
    quiet();
    @(negedge clk);
    check_reset("rst2");
    reset = 1'b1;
    @(negedge clk);

    // ---- randomized traffic against the reference model, then a quiet drain
    m_pend = '0; m_hold = '0; m_drop = '0; m_ptr = 0; m_ov = 1'b0; m_od = '0;
    for (int i = 0; i < NL; i++) mq[i].delete();
    for (int cyc = 0; cyc < 560; cyc++) begin
      for (int i = 0; i < NL; i++) pred_urdy[i] = (mq[i].size() < DEPTH);
      #1;
      chk($sformatf("rnd%0d_dvalid", cyc), bus.down_tx_valid, m_pend);
      if (m_pend != '0) chk($sformatf("rnd%0d_ddata", cyc), bus.down_tx_data, {NL{m_hold}});
      chk($sformatf("rnd%0d_uvalid", cyc), bus.up_tx_valid, m_ov);
      if (m_ov) chk($sformatf("rnd%0d_udata", cyc), bus.up_tx_data, m_od);
      chk($sformatf("rnd%0d_urdy", cyc), bus.up_rx_ready, pred_urdy);
      chk($sformatf("rnd%0d_drop", cyc), bus.drop_count, m_drop);

      if (cyc < 500) begin
        bus.down_rx_valid = ($urandom_range(0, 9) < 6);
        bus.down_rx_data  = {dests[$urandom_range(0, 7)], 24'($urandom), 32'($urandom)};
        bus.down_tx_ready = 4'($urandom_range(0, 15));
        bus.up_rx_valid   = 4'($urandom_range(0, 15));
        for (int i = 0; i < NL; i++) bus.up_rx_data[i*64 +: 64] = {32'($urandom), 32'($urandom)};
        bus.up_tx_ready   = ($urandom_range(0, 3) != 0);
      end else begin
        quiet();
        bus.down_tx_ready = '1;
        bus.up_tx_ready   = 1'b1;
      end
      pred_drdy = ((m_pend & ~bus.down_tx_ready) == '0);
      #1 chk($sformatf("rnd%0d_drdy", cyc), bus.down_rx_ready, pred_drdy);

      // model: down path
      nxt_pend = m_pend & ~bus.down_tx_ready;
      if (bus.down_rx_valid && pred_drdy) begin
        d = bus.down_rx_data[63:56];
        if (d == 8'hFF) begin
          nxt_pend = 4'hF;
          m_hold   = bus.down_rx_data;
        end else if (d >= 8'd1 && d <= 8'(NL)) begin
          nxt_pend = nxt_pend | (4'b0001 << (d - 8'd1));
          m_hold   = bus.down_rx_data;
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
      m_pend = nxt_pend;
      // model: up path (arbitrate on pre-write contents, then accept writes)
      if (!m_ov || bus.up_tx_ready) begin
        found = 1'b0;
        for (int k = 0; k < NL; k++) begin
          j = (m_ptr + k) % NL;
          if (!found && mq[j].size() > 0) begin
            found = 1'b1;
            m_od  = tag(mq[j].pop_front(), j);
            m_ptr = (j + 1) % NL;
          end
        end
        m_ov = found;
      end
      for (int i = 0; i < NL; i++)
        if (bus.up_rx_valid[i] && pred_urdy[i]) mq[i].push_back(bus.up_rx_data[i*64 +: 64]);
      @(negedge clk);
    end

    // ---- drop counter saturation
    quiet();
    bus.down_rx_data  = {8'h00, 56'h5A};
    bus.down_rx_valid = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    chk("sat_mid", bus.drop_count, (32'(m_drop) + 1000 > 32'hFFFF) ? 16'hFFFF : m_drop + 16'd1000);
    repeat (65537) @(negedge clk);
    #1;
    chk("sat_full", bus.drop_count, 16'hFFFF);
    chk("sat_no_valid", bus.down_tx_valid, 0);
    bus.down_rx_valid = 1'b0;

    // ---- reset during a partially delivered broadcast with up traffic in flight
    @(negedge clk);
    bus.up_rx_valid = 4'b0001;
    bus.up_rx_data[63:0] = mk(0, 40);
    bus.down_rx_data  = {8'hFF, 56'h00C0_FFEE};
    bus.down_rx_valid = 1'b1;
    @(negedge clk);
    bus.up_rx_data[63:0] = mk(0, 41);
    bus.down_rx_valid = 1'b0;
    bus.down_tx_ready = 4'b0101;
    @(negedge clk);
    bus.up_rx_valid   = '0;
    bus.down_tx_ready = '0;
    #1;
    chk("mid_pend", bus.down_tx_valid, 4'b1010);
    chk("mid_uvalid", bus.up_tx_valid, 1);
    #1 reset = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    reset = 1'b1;
    bus.up_tx_ready   = 1'b1;
    bus.down_tx_ready = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_dvalid%0d", c), bus.down_tx_valid, 0);
      chk($sformatf("post_uvalid%0d", c), bus.up_tx_valid, 0);
      chk($sformatf("post_urdy%0d", c), bus.up_rx_ready, 4'hF);
      chk($sformatf("post_drdy%0d", c), bus.down_rx_ready, 1);
    end
    bus.down_tx_ready = '0;
    bus.down_rx_data  = {8'h01, 56'h77};
    bus.down_rx_valid = 1'b1;
    @(negedge clk);
    bus.down_rx_valid = 1'b0;
    #1 chk("post_unicast", bus.down_tx_valid, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/leaf_link_hub.md
Name: leaf_link_hub

Overview:
- Synthesisable root-side link hub between one root port and NUM_LEAVES leaf ports. All links are 64-bit valid/ready.
- Down path: a root message is routed to one leaf (unicast) or to all leaves (broadcast), using a destination FPGA-ID field in the message.
- Up path: a per-leaf FIFO feeds a round-robin arbiter that merges leaf traffic onto the single root up-link.
- This is the parametrised successor of the single-leaf point-to-point hookup, for multi-FPGA decoder trees.

Parameters:
- NUM_LEAVES, 4, number of leaf ports (1..254). Leaf i has FPGA ID i+1.
- DATA_WIDTH, 64, message width.
- DEST_LSB, 56, LSB of the 8-bit destination/source ID field, bits [DEST_LSB+7:DEST_LSB].
- BROADCAST_ID, 8'hFF, destination value meaning "all leaves".
- FIFO_DEPTH, 4, entries per up-path FIFO; power of two, >=2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- down_rx_data  in  DATA_WIDTH  message from root.
- down_rx_valid  in  1  root message valid.
- down_rx_ready  out  1  hub accepts root message.
- down_tx_data  out  DATA_WIDTH*NUM_LEAVES  per-leaf message; slice i goes to leaf i.
- down_tx_valid  out  NUM_LEAVES  per-leaf valid.
- down_tx_ready  in  NUM_LEAVES  per-leaf ready.
- up_rx_data  in  DATA_WIDTH*NUM_LEAVES  per-leaf upward message.
- up_rx_valid  in  NUM_LEAVES  per-leaf valid.
- up_rx_ready  out  NUM_LEAVES  per-leaf FIFO not full.
- up_tx_data  out  DATA_WIDTH  merged message to root.
- up_tx_valid  out  1  merged valid.
- up_tx_ready  in  1  root ready.
- drop_count  out  16  count of root messages with an invalid destination.

Behaviour:
- Reset (reset low, asynchronous):
  - down_tx_valid=0, up_tx_valid=0, up_tx_data=0, down_tx_data=0, drop_count=0.
  - All FIFOs empty; up_rx_ready all 1.
  - Round-robin pointer=0; hold register empty.
  - Reset asserted mid-transfer discards all in-flight messages; no partial broadcast survives.
- Down hold register, two states:
  - IDLE: hold empty.
  - HOLD: message held, with pending mask P[NUM_LEAVES-1:0].
- Root handshake (down_rx_valid & down_rx_ready) with destination field D:
  - D==BROADCAST_ID: P = all ones.
  - 1<=D<=NUM_LEAVES: P = one-hot bit D-1.
  - Otherwise: message consumed and dropped, P stays 0, drop_count increments and saturates at 16'hFFFF.
- Timing and ready:
  - down_tx_valid = P; down_tx_data replicates the held message on every slice.
  - Each leaf's P bit clears on that leaf's handshake. HOLD returns to IDLE when P becomes 0.
  - down_rx_ready = (hold empty) | ((P & ~down_tx_ready)==0). This allows back-to-back messages at 1 per cycle when the leaves are ready.
  - Latency: root handshake at edge N gives down_tx_valid high from edge N onward (registered output).
- Broadcast: leaves may accept in different cycles. The next message is not accepted until every leaf has taken the current one. Order is preserved per leaf.
- Up FIFOs:
  - up_rx_ready[i] = ~full[i] (registered, no full-passthrough).
  - A write to a full FIFO cannot occur.
  - Simultaneous read and write on a non-full FIFO is allowed; count is unchanged.
- Arbiter:
  - The output register loads when (up_tx_valid==0 | up_tx_ready) and at least one FIFO is non-empty.
  - Grant goes to the first non-empty FIFO at or after the pointer, searching modulo NUM_LEAVES.
  - On load, pointer = grant+1, wrapping NUM_LEAVES-1 -> 0.
  - Minimum latency: leaf write at edge N gives up_tx_valid at edge N+1.
  - up_tx_data is stable while up_tx_valid & ~up_tx_ready.
  - Sustained 1 message/cycle when up_tx_ready stays high.

Optional Feature:
- Macro LINK_HUB_SRC_TAG_EN.
- Defined: when an up message is loaded from leaf i, the hub overwrites bits [DEST_LSB+7:DEST_LSB] with i+1, so the root sees the source ID.
- Undefined: up messages pass through unmodified.

Test Plan:
- Unicast: NUM_LEAVES=4, root sends D=3, payload 0x...A5 -> only down_tx_valid[2] rises, 1 cycle after the handshake; data matches; drop_count=0.
- Broadcast with skew: D=8'hFF; leaves ready at cycles 0,2,5,1 -> each valid drops on its own handshake; down_rx_ready low until cycle 5; next message accepted on cycle 5.
- Invalid destination: D=0, then D=7 -> both consumed, no down_tx_valid, drop_count=2. Force 65537 drops -> drop_count holds 16'hFFFF.
- Round-robin fairness: all 4 leaves push 3 messages each with up_tx_ready=1 -> output source order 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle. With LINK_HUB_SRC_TAG_EN defined, the ID field reads 1,2,3,4,...
- Backpressure/full: up_tx_ready=0, leaf 1 pushes 5 messages -> up_rx_ready[1] low after 4 FIFO entries plus the output register is occupied; release -> all 5 delivered in order, up_tx_data stable while stalled.
- Reset mid-broadcast: reset low with P=4'b1010 -> all valids 0 asynchronously; after release, the hub is IDLE and FIFOs are empty.
